// File: rtl/control_pkg.sv
// Shared types and constants for the access-control block.
package control_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DENY  = 2'd2,
        LOCK  = 2'd3
    } state_e;

    localparam int NUM_IDS = 4;

    localparam logic [31:0] DEF_ID_0 = 32'h0000_1234;
    localparam logic [31:0] DEF_ID_1 = 32'h0000_ABCD;
    localparam logic [31:0] DEF_ID_2 = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_ID_3 = 32'h1357_9BDF;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/control_id_matcher.sv
// Combinational match of a presented ID against the four authorized IDs.
module id_matcher
    import control_pkg::*;
#(
    parameter logic [31:0] ID_0 = DEF_ID_0,
    parameter logic [31:0] ID_1 = DEF_ID_1,
    parameter logic [31:0] ID_2 = DEF_ID_2,
    parameter logic [31:0] ID_3 = DEF_ID_3
) (
    input  logic [31:0] id_i,
    output logic        match_o
);

    localparam logic [31:0] IDS [NUM_IDS] = '{ID_0, ID_1, ID_2, ID_3};

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (id_i == IDS[i]) begin
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control.sv
// Access-control FSM (IDLE/GRANT/DENY/LOCK) with hold timer and fail counter.
// Lockout is built only when CONTROL_LOCKOUT_EN is defined.
module control
    import control_pkg::*;
#(
    parameter int          DOOR_CYCLES = 2,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 4,
    parameter logic [31:0] ID_0        = DEF_ID_0,
    parameter logic [31:0] ID_1        = DEF_ID_1,
    parameter logic [31:0] ID_2        = DEF_ID_2,
    parameter logic [31:0] ID_3        = DEF_ID_3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id,
    output logic        red,
    output logic        blue,
    output logic        green,
    output logic        door
);

    localparam int TMR_MAX = imax(DOOR_CYCLES, LOCK_CYCLES);
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

    generate
        if (DOOR_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_FAIL < 1) begin : g_bad_param
            $error("control: DOOR_CYCLES, LOCK_CYCLES and MAX_FAIL must all be >= 1");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               match;
    logic               red_q, green_q, door_q;

    id_matcher #(
        .ID_0(ID_0),
        .ID_1(ID_1),
        .ID_2(ID_2),
        .ID_3(ID_3)
    ) u_id_matcher (
        .id_i    (id),
        .match_o (match)
    );

`ifdef CONTROL_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic              blue_q;

    // Saturating increment: the counter can never wrap past MAX_FAIL.
    assign fail_inc = (fail_q >= FAIL_W'(MAX_FAIL)) ? FAIL_W'(MAX_FAIL) : fail_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef CONTROL_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            IDLE, DENY: begin
                if (id == 32'h0) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d = GRANT;
                    timer_d = TMR_W'(DOOR_CYCLES);
`ifdef CONTROL_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
`ifdef CONTROL_LOCKOUT_EN
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        state_d = LOCK;
                        timer_d = TMR_W'(LOCK_CYCLES);
                        fail_d  = '0;
                    end else begin
                        state_d = DENY;
                        fail_d  = fail_inc;
                    end
`else
                    state_d = DENY;
`endif
                end
            end
            // GRANT and LOCK count down and ignore id entirely.
            GRANT, LOCK: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            red_q   <= 1'b0;
            green_q <= 1'b0;
            door_q  <= 1'b0;
`ifdef CONTROL_LOCKOUT_EN
            fail_q  <= '0;
            blue_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            red_q   <= (state_d == DENY);
            green_q <= (state_d == GRANT);
            door_q  <= (state_d == GRANT);
`ifdef CONTROL_LOCKOUT_EN
            fail_q  <= fail_d;
            blue_q  <= (state_d == LOCK);
`endif
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign door  = door_q;
`ifdef CONTROL_LOCKOUT_EN
    assign blue  = blue_q;
`else
    assign blue  = 1'b0;
`endif

endmodule

// File: tb/tb_control.sv
// Randomized self-checking bench for control against a cycle-count reference model.
module tb_control;

    localparam int DOOR  = 2;
    localparam int MAXF  = 3;
    localparam int LOCKC = 4;
`ifdef CONTROL_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id;
    logic        red, blue, green, door;

    int checks   = 0;
    int failures = 0;

    logic [31:0] auth [4] = '{32'h0000_1234, 32'h0000_ABCD, 32'hDEAD_BEEF, 32'h1357_9BDF};

    // Reference model: remaining grant/lock cycles, deny flag, failure count.
    int m_grant = 0;
    int m_lock  = 0;
    int m_fails = 0;
    bit m_deny  = 1'b0;

    control #(
        .DOOR_CYCLES(DOOR),
        .MAX_FAIL   (MAXF),
        .LOCK_CYCLES(LOCKC),
        .ID_0       (32'h0000_1234),
        .ID_1       (32'h0000_ABCD),
        .ID_2       (32'hDEAD_BEEF),
        .ID_3       (32'h1357_9BDF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .id    (id),
        .red   (red),
        .blue  (blue),
        .green (green),
        .door  (door)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got red,blue,green,door=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic bit is_auth(input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v == auth[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input logic [31:0] v);
        if (r) begin
            m_grant = 0;
            m_lock  = 0;
            m_fails = 0;
            m_deny  = 1'b0;
        end else if (m_grant > 0) begin
            m_grant--;
        end else if (m_lock > 0) begin
            m_lock--;
        end else begin
            m_deny = 1'b0;
            if (v == 32'h0) begin
                // stays idle, failures remembered
            end else if (is_auth(v)) begin
                m_grant = DOOR;
                m_fails = 0;
            end else if (LOCKOUT) begin
                m_fails++;
                if (m_fails == MAXF) begin
                    m_lock  = LOCKC;
                    m_fails = 0;
                end else begin
                    m_deny = 1'b1;
                end
            end else begin
                m_deny = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] model_out();
        return {m_deny, (m_lock > 0), (m_grant > 0), (m_grant > 0)};
    endfunction

    task automatic step(input string tag, input bit r, input logic [31:0] v);
        reset = r;
        id    = v;
        @(posedge clk);
        model_edge(r, v);
        @(negedge clk);
        check_eq(tag, {red, blue, green, door}, model_out());
    endtask

    function automatic logic [31:0] rand_id();
        int sel;
        logic [31:0] v;
        sel = $urandom_range(0, 9);
        if (sel < 3) begin
            v = 32'h0;
        end else if (sel < 6) begin
            v = auth[$urandom_range(0, 3)];
        end else if (sel < 8) begin
            v = 32'($urandom_range(1, 15));
        end else begin
            v = $urandom;
        end
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        id    = 32'h0;

        // reset, then idle
        step("reset", 1'b1, 32'h0);
        check_eq("reset_const", {red, blue, green, door}, 4'b0000);
        step("idle", 1'b0, 32'h0);

        // single grant holds for DOOR cycles
        step("grant_in", 1'b0, 32'h0000_1234);
        check_eq("grant_const", {red, blue, green, door}, 4'b0011);
        for (int i = 0; i < 3; i++) step("grant_hold", 1'b0, 32'h0);
        check_eq("grant_done", {red, blue, green, door}, 4'b0000);

        // single denial
        step("deny_in", 1'b0, 32'h0000_0005);
        check_eq("deny_const", {red, blue, green, door}, 4'b1000);
        step("deny_out", 1'b0, 32'h0);

        // two more failures (fail count persists across idle), id ignored during lock
        step("fail_6", 1'b0, 32'h0000_0006);
        step("fail_7", 1'b0, 32'h0000_0007);
        step("lock_ign", 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) step("lock_hold", 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step("after_lock", 1'b0, 32'h0);

        // two failures, grant clears the counter, one more failure is only red
        step("f1", 1'b0, 32'h0000_0005);
        step("f2", 1'b0, 32'h0000_0006);
        step("clr_grant", 1'b0, 32'h1357_9BDF);
        step("g_hold", 1'b0, 32'h0);
        step("g_end", 1'b0, 32'h0);
        step("f_after", 1'b0, 32'h0000_0007);
        check_eq("f_after_const", {red, blue, green, door}, 4'b1000);
        step("f_idle", 1'b0, 32'h0);

        // reset aborts grant
        step("g_abort_in", 1'b0, 32'h0000_ABCD);
        step("g_abort_rst", 1'b1, 32'h0000_ABCD);
        check_eq("g_abort_const", {red, blue, green, door}, 4'b0000);

        // reset aborts lock
        for (int i = 0; i < 3; i++) step("l_abort_fail", 1'b0, 32'h0000_0009);
        step("l_abort_rst", 1'b1, 32'h0000_0009);
        check_eq("l_abort_const", {red, blue, green, door}, 4'b0000);
        step("l_abort_idle", 1'b0, 32'h0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            step("rand", ($urandom_range(0, 99) < 3), rand_id());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter DOOR_CYCLES, default 2: number of cycles green/door stay asserted after a granted request.
REQ-002 Parameter MAX_FAIL, default 3: consecutive denied requests that trigger lockout.
REQ-003 Parameter LOCK_CYCLES, default 4: number of cycles the lockout lasts.
REQ-004 Parameters ID_0..ID_3, defaults 32'h0000_1234, 32'h0000_ABCD, 32'hDEAD_BEEF, 32'h1357_9BDF: the authorized IDs.
REQ-005 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 id  input  32  presented ID; 32'h0 means "no request".
REQ-008 red  output  1  access denied indication.
REQ-009 blue  output  1  lockout indication.
REQ-010 green  output  1  access granted indication.
REQ-011 door  output  1  door-open command.

Function
REQ-012 The block SHALL be an FSM with states IDLE, GRANT, DENY and LOCK; all outputs SHALL be registered and decoded from the state.
REQ-013 Outputs per state SHALL be: IDLE all 0; GRANT green=1, door=1; DENY red=1; LOCK blue=1; no other output combination is legal.
REQ-014 id SHALL be evaluated only at rising edges where the state is IDLE or DENY; in GRANT and LOCK, id SHALL be ignored.
REQ-015 When evaluated, id==0 SHALL cause a transition to IDLE, or keep the block in IDLE.
REQ-016 When evaluated, an id equal to any of ID_0..ID_3 SHALL cause a transition to GRANT, load the hold timer with DOOR_CYCLES and clear the fail counter.
REQ-017 When evaluated, a nonzero, unauthorized id SHALL increment the fail counter.
REQ-018 If the incremented fail count equals MAX_FAIL, the block SHALL go to LOCK, load the timer with LOCK_CYCLES and clear the counter; otherwise it SHALL go to DENY.
REQ-019 Latency: outputs SHALL reflect the decision for a given id exactly one clock after the edge that samples it.
REQ-020 GRANT SHALL last exactly DOOR_CYCLES cycles, then return to IDLE.
REQ-021 LOCK SHALL last exactly LOCK_CYCLES cycles, then return to IDLE.
REQ-022 DENY SHALL last one cycle unless the next evaluated id re-enters DENY or goes to GRANT or LOCK.
REQ-023 An id==0 or a grant SHALL NOT reset the fail counter except as stated in REQ-016; the fail count SHALL persist across IDLE.
REQ-024 The fail counter SHALL saturate at MAX_FAIL and never wrap.
REQ-025 The timer SHALL be wide enough for max(DOOR_CYCLES, LOCK_CYCLES).

Reset
REQ-026 When reset=1 at a rising edge, the state SHALL become IDLE, the fail counter and timer SHALL be 0, and red, blue, green and door SHALL all be 0.
REQ-027 Reset SHALL take priority over any request and SHALL abort GRANT or LOCK mid-count.
REQ-028 id SHALL be ignored in any cycle in which reset=1.

Configuration
REQ-029 With macro CONTROL_LOCKOUT_EN defined, the lockout behaviour SHALL be as specified above.
REQ-030 Without CONTROL_LOCKOUT_EN, the LOCK state and fail counter SHALL be absent, blue SHALL be tied to 0, and every unauthorized nonzero id SHALL go to DENY.

Structure
REQ-031 Package control_pkg SHALL hold the state enum typedef, NUM_IDS=4, and the default authorized-ID constants.
REQ-032 Sub-module id_matcher SHALL perform the combinational comparison of id against the four authorized IDs and output a match flag; the FSM, counter and timer SHALL live in control.

Verification
REQ-033 Scenario: reset=1 for one cycle, then id=0 -> red=blue=green=door=0.
REQ-034 Scenario: id=32'h0000_1234 for one cycle, then id=0 -> green=door=1 for exactly 2 cycles, then all outputs 0.
REQ-035 Scenario: id=32'h0000_0005, then id=0 -> red=1 for one cycle, then IDLE with fail count 1.
REQ-036 Scenario: three consecutive evaluated unauthorized ids (5, 6, 7) -> red, red, then blue=1 for 4 cycles; id=32'hDEAD_BEEF applied during lock is ignored.
REQ-037 Scenario: two failures followed by id=32'h1357_9BDF -> grant and fail counter cleared; one further failure gives red, not blue.
REQ-038 Scenario: reset=1 asserted in the middle of GRANT or LOCK -> all outputs 0 at the next edge.
